csi2_packet_parser: RTL and testbench



---
 rtl/csi2_pkg.sv | 26 ++
 rtl/csi2_ecc.sv | 17 +
 rtl/csi2_packet_parser.sv | 174 +++++++++++++++++
 tb/tb_csi2_packet_parser.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared constants and types for the CSI-2 receive path: data types,
// header ECC parity masks and the packet parser state encoding.
package csi2_pkg;

    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_LONG_MIN    = 6'h10;
    localparam logic [5:0] DT_RAW8        = 6'h2A;

    // Parity bit n is the XOR of the 24-bit header {WC, DI} under mask [n].
    localparam logic [5:0][23:0] ECC_MASKS = {
        24'hEFFC00,   // P5
        24'hDF03F0,   // P4
        24'hB8E38E,   // P3
        24'h749A6D,   // P2
        24'hF2555B,   // P1
        24'hF12CB7    // P0
    };

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DISCARD
    } state_t;

endpackage

// File: rtl/csi2_ecc.sv
// Combinational CSI-2 packet header parity generator (6-bit Hamming code
// over the 24-bit {WC, DI} header, bit 0 = DI[0]).
module csi2_ecc
    import csi2_pkg::*;
(
    input  logic [23:0] header,
    output logic [5:0]  parity
);

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_parity
            assign parity[gi] = ^(header & ECC_MASKS[gi]);
        end
    endgenerate

endmodule

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser: checks header ECC, tracks frame start/end, and
// forwards only the payload words of matching long packets, 4 bytes/cycle.
module csi2_packet_parser
    import csi2_pkg::*;
#(
    parameter logic [5:0]  DATA_TYPE       = DT_RAW8,
    parameter logic [1:0]  VIRTUAL_CHANNEL = 2'd0,
    parameter logic [15:0] MAX_WORD_COUNT  = 16'd640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in [0:3],
    input  logic       data_valid,
    output logic [7:0] data_out [0:3],
    output logic       data_enable,
    output logic       frame_start,
    output logic       frame_end,
    output logic       line_start,
    output logic       in_frame,
    output logic       header_error,
    output logic       packet_error
);

    state_t      state_reg, state_next;
    logic [13:0] words_left_reg, words_left_next;
    logic        first_word_reg, first_word_next;
    logic        in_frame_reg, in_frame_next;
    logic        data_enable_reg, data_enable_next;
    logic        line_start_reg, line_start_next;
    logic        frame_start_reg, frame_start_next;
    logic        frame_end_reg, frame_end_next;
    logic        header_error_reg, header_error_next;
    logic        packet_error_reg, packet_error_next;
    logic        load_data;
    logic [7:0]  data_out_reg [0:3];

    // Header fields are only meaningful on the first valid cycle of a burst (IDLE).
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic [5:0]  hdr_parity;
    logic        hdr_ecc_ok;
    logic        hdr_match;
    logic        hdr_wc_bad;

    assign hdr_di     = data_in[0];
    assign hdr_wc     = {data_in[2], data_in[1]};
    assign hdr_ecc_ok = (data_in[3] == {2'b00, hdr_parity});
    assign hdr_match  = (hdr_di[7:6] == VIRTUAL_CHANNEL) && (hdr_di[5:0] == DATA_TYPE)
                        && in_frame_reg;
    assign hdr_wc_bad = (hdr_wc == 16'd0) || (hdr_wc[1:0] != 2'b00)
                        || (hdr_wc > MAX_WORD_COUNT);

    csi2_ecc u_ecc (
        .header (hdr_wc_di()),
        .parity (hdr_parity)
    );

    function automatic logic [23:0] hdr_wc_di();
        return {hdr_wc, hdr_di};
    endfunction

    // Next-state and next-output decode; single-cycle pulses default low.
    always_comb begin
        state_next        = state_reg;
        words_left_next   = words_left_reg;
        first_word_next   = first_word_reg;
        in_frame_next     = in_frame_reg;
        data_enable_next  = 1'b0;
        line_start_next   = 1'b0;
        frame_start_next  = 1'b0;
        frame_end_next    = 1'b0;
        header_error_next = 1'b0;
        packet_error_next = 1'b0;
        load_data         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (data_valid) begin
                    state_next = DISCARD;
                    if (!hdr_ecc_ok) begin
                        header_error_next = 1'b1;
                    end else if (hdr_di[5:0] == DT_FRAME_START) begin
                        frame_start_next = 1'b1;
                        in_frame_next    = 1'b1;
                    end else if (hdr_di[5:0] == DT_FRAME_END) begin
                        frame_end_next = 1'b1;
                        in_frame_next  = 1'b0;
                    end else if ((hdr_di[5:0] >= DT_LONG_MIN) && hdr_match) begin
                        if (hdr_wc_bad) begin
                            packet_error_next = 1'b1;
                        end else begin
                            words_left_next = hdr_wc[15:2];
                            first_word_next = 1'b1;
                            state_next      = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (data_valid) begin
                    data_enable_next = 1'b1;
                    load_data        = 1'b1;
                    line_start_next  = first_word_reg;
                    first_word_next  = 1'b0;
                    words_left_next  = words_left_reg - 14'd1;
                    // Remaining burst bytes (CRC, padding) are dropped in DISCARD.
                    if (words_left_reg == 14'd1) begin
                        state_next = DISCARD;
                    end
                end else begin
                    packet_error_next = 1'b1;
                    state_next        = IDLE;
                end
            end
            DISCARD: begin
                if (!data_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered control outputs; reset silently aborts any packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            words_left_reg   <= '0;
            first_word_reg   <= 1'b0;
            in_frame_reg     <= 1'b0;
            data_enable_reg  <= 1'b0;
            line_start_reg   <= 1'b0;
            frame_start_reg  <= 1'b0;
            frame_end_reg    <= 1'b0;
            header_error_reg <= 1'b0;
            packet_error_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            words_left_reg   <= words_left_next;
            first_word_reg   <= first_word_next;
            in_frame_reg     <= in_frame_next;
            data_enable_reg  <= data_enable_next;
            line_start_reg   <= line_start_next;
            frame_start_reg  <= frame_start_next;
            frame_end_reg    <= frame_end_next;
            header_error_reg <= header_error_next;
            packet_error_reg <= packet_error_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Payload byte register per lane; holds its value between words.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out_reg[gi] <= 8'h00;
                end else if (load_data) begin
                    data_out_reg[gi] <= data_in[gi];
                end
            end
            assign data_out[gi] = data_out_reg[gi];
        end
    endgenerate

    assign data_enable  = data_enable_reg;
    assign line_start   = line_start_reg;
    assign frame_start  = frame_start_reg;
    assign frame_end    = frame_end_reg;
    assign in_frame     = in_frame_reg;
    assign header_error = header_error_reg;
    assign packet_error = packet_error_reg;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Self-checking bench for csi2_packet_parser: directed packet table,
// hand-written timing/reset sequences, and randomized packets checked
// against a packet-level reference model.
module tb_csi2_packet_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in [0:3];
    logic       data_valid;
    logic [7:0] data_out [0:3];
    logic       data_enable;
    logic       frame_start;
    logic       frame_end;
    logic       line_start;
    logic       in_frame;
    logic       header_error;
    logic       packet_error;

    csi2_packet_parser dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_out     (data_out),
        .data_enable  (data_enable),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .line_start   (line_start),
        .in_frame     (in_frame),
        .header_error (header_error),
        .packet_error (packet_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fs;
        int fe;
        int he;
        int pe;
        int ndata;
        int in_frame;
    } exp_t;

    typedef struct {
        logic [31:0] hdr;       // {DI, WC lo, WC hi, ECC} = lane bytes 0..3
        bit          auto_ecc;  // replace ECC byte with the reference parity
        int          nwords;    // words following the header in the burst
        exp_t        e;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    int acc_fs, acc_fe, acc_he, acc_pe, acc_ls, acc_ls_bad;
    logic [31:0] obs_q[$];
    logic [31:0] sent_q[$];
    logic [31:0] last_word;
    int          model_in_frame;

    // Data-bit positions covered by each ECC parity bit (CSI-2 Hamming table).
    int ecc_bits [6][14] = '{
        '{0, 1, 2, 4, 5, 7, 10, 11, 13, 16, 20, 21, 22, 23},
        '{0, 1, 3, 4, 6, 8, 10, 12, 14, 17, 20, 21, 22, 23},
        '{0, 2, 3, 5, 6, 9, 11, 12, 15, 18, 20, 21, 22, -1},
        '{1, 2, 3, 7, 8, 9, 13, 14, 15, 19, 20, 21, 23, -1},
        '{4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 22, 23, -1},
        '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21, 22, 23, -1}
    };

    function automatic logic [5:0] ecc_model(input logic [23:0] d);
        logic [5:0] p = '0;
        for (int b = 0; b < 6; b++)
            for (int k = 0; k < 14; k++)
                if (ecc_bits[b][k] >= 0) p[b] = p[b] ^ d[ecc_bits[b][k]];
        return p;
    endfunction

    function automatic logic [31:0] with_ecc(input logic [31:0] hdr);
        logic [31:0] h = hdr;
        h[7:0] = {2'b00, ecc_model({hdr[15:8], hdr[23:16], hdr[31:24]})};
        return h;
    endfunction

    // Packet-level outcome from the header rules, burst length and frame state.
    function automatic exp_t model_packet(input logic [31:0] hdr, input int nwords,
                                          input int in_fr);
        exp_t e = '{0, 0, 0, 0, 0, 0};
        logic [7:0]  di  = hdr[31:24];
        logic [15:0] wc  = {hdr[15:8], hdr[23:16]};
        logic [7:0]  ecc = hdr[7:0];
        int words;
        e.in_frame = in_fr;
        if (ecc != {2'b00, ecc_model({wc, di})}) begin
            e.he = 1;
        end else if (di[5:0] == 6'h00) begin
            e.fs = 1;
            e.in_frame = 1;
        end else if (di[5:0] == 6'h01) begin
            e.fe = 1;
            e.in_frame = 0;
        end else if (di == 8'h2A && in_fr != 0) begin
            if (wc == 0 || (wc % 4) != 0 || wc > 640) begin
                e.pe = 1;
            end else begin
                words = int'(wc) / 4;
                e.ndata = (nwords < words) ? nwords : words;
                e.pe = (nwords < words) ? 1 : 0;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic collect();
        logic [31:0] w;
        w = {data_out[0], data_out[1], data_out[2], data_out[3]};
        acc_fs += int'(frame_start);
        acc_fe += int'(frame_end);
        acc_he += int'(header_error);
        acc_pe += int'(packet_error);
        acc_ls += int'(line_start);
        if (data_enable) begin
            if ((obs_q.size() == 0) != line_start) acc_ls_bad++;
            obs_q.push_back(w);
        end else if (line_start) begin
            acc_ls_bad++;
        end
    endtask

    // Drive one word (inputs change just after the falling edge), then sample
    // the registered response at the next falling edge.
    task automatic step(input bit v, input logic [31:0] w);
        data_valid = v;
        data_in[0] = w[31:24];
        data_in[1] = w[23:16];
        data_in[2] = w[15:8];
        data_in[3] = w[7:0];
        @(negedge clk);
        collect();
    endtask

    task automatic run_packet(input logic [31:0] hdr, input int nwords);
        logic [31:0] w;
        acc_fs = 0; acc_fe = 0; acc_he = 0; acc_pe = 0; acc_ls = 0; acc_ls_bad = 0;
        obs_q.delete();
        sent_q.delete();
        step(1'b1, hdr);
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            sent_q.push_back(w);
            step(1'b1, w);
        end
        step(1'b0, 32'h0);
    endtask

    task automatic check_packet(input string tag, input logic [31:0] hdr, input exp_t e);
        chk($sformatf("%s fs", tag), acc_fs, e.fs);
        chk($sformatf("%s fe", tag), acc_fe, e.fe);
        chk($sformatf("%s hdr_err", tag), acc_he, e.he);
        chk($sformatf("%s pkt_err", tag), acc_pe, e.pe);
        chk($sformatf("%s ls_count", tag), acc_ls, (e.ndata > 0) ? 1 : 0);
        chk($sformatf("%s ls_align", tag), acc_ls_bad, 0);
        chk($sformatf("%s n_data", tag), obs_q.size(), e.ndata);
        for (int i = 0; i < e.ndata && i < obs_q.size(); i++)
            chk($sformatf("%s word%0d", tag, i), obs_q[i], sent_q[i]);
        chk($sformatf("%s in_frame", tag), in_frame, e.in_frame);
        if (e.ndata > 0 && e.ndata <= sent_q.size()) last_word = sent_q[e.ndata - 1];
        chk($sformatf("%s data_hold", tag),
            {data_out[0], data_out[1], data_out[2], data_out[3]}, last_word);
        $display("pkt %s hdr=%08h words=%0d fs=%0d fe=%0d he=%0d pe=%0d data=%0d",
                 tag, hdr, sent_q.size(), acc_fs, acc_fe, acc_he, acc_pe, obs_q.size());
        model_in_frame = e.in_frame;
    endtask

    vec_t tbl [20];

    initial begin
        logic [31:0] hdr, w;
        logic [15:0] wc;
        exp_t        e;
        int          r, words, nw;

        tbl[0]  = '{32'h01000007, 1'b0, 0,   '{0, 1, 0, 0, 0,   0}};  // FE, not in frame
        tbl[1]  = '{32'h00000000, 1'b0, 0,   '{1, 0, 0, 0, 0,   1}};  // FS
        tbl[2]  = '{32'h2A080035, 1'b0, 3,   '{0, 0, 0, 0, 2,   1}};  // normal line
        tbl[3]  = '{32'h2A080034, 1'b0, 3,   '{0, 0, 1, 0, 0,   1}};  // bad ECC
        tbl[4]  = '{32'h2A080035, 1'b0, 3,   '{0, 0, 0, 0, 2,   1}};  // recovers
        tbl[5]  = '{32'h2A060000, 1'b1, 3,   '{0, 0, 0, 1, 0,   1}};  // WC=6
        tbl[6]  = '{32'h2B080000, 1'b1, 3,   '{0, 0, 0, 0, 0,   1}};  // DT 0x2B
        tbl[7]  = '{32'h6A080000, 1'b1, 3,   '{0, 0, 0, 0, 0,   1}};  // VC=1
        tbl[8]  = '{32'h2A000000, 1'b1, 1,   '{0, 0, 0, 1, 0,   1}};  // WC=0
        tbl[9]  = '{32'h2A840200, 1'b1, 1,   '{0, 0, 0, 1, 0,   1}};  // WC=644
        tbl[10] = '{32'h2A800200, 1'b1, 161, '{0, 0, 0, 0, 160, 1}};  // WC=640
        tbl[11] = '{32'h05000000, 1'b1, 1,   '{0, 0, 0, 0, 0,   1}};  // short DT 0x05
        tbl[12] = '{32'h2A080035, 1'b0, 1,   '{0, 0, 0, 1, 1,   1}};  // truncated
        tbl[13] = '{32'h01000047, 1'b0, 0,   '{0, 0, 1, 0, 0,   1}};  // ECC[7:6] set
        tbl[14] = '{32'h00000000, 1'b0, 0,   '{1, 0, 0, 0, 0,   1}};  // FS in frame
        tbl[15] = '{32'h01000007, 1'b0, 0,   '{0, 1, 0, 0, 0,   0}};  // FE
        tbl[16] = '{32'h01000007, 1'b0, 0,   '{0, 1, 0, 0, 0,   0}};  // FE again
        tbl[17] = '{32'h2A080035, 1'b0, 3,   '{0, 0, 0, 0, 0,   0}};  // before FS
        tbl[18] = '{32'h00000000, 1'b0, 0,   '{1, 0, 0, 0, 0,   1}};  // FS
        tbl[19] = '{32'h2A040000, 1'b1, 1,   '{0, 0, 0, 0, 1,   1}};  // WC=4, no trailer

        reset = 1'b1;
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) data_in[i] = 8'h00;
        last_word = 32'h0;
        model_in_frame = 0;
        @(negedge clk);

        // Reset for 3 cycles, then FE: pulse exactly one cycle after the header.
        repeat (3) step(1'b0, 32'h0);
        chk("reset flags", {data_enable, line_start, frame_start, frame_end, in_frame,
                            header_error, packet_error}, 32'h0);
        chk("reset data_out", {data_out[0], data_out[1], data_out[2], data_out[3]}, 32'h0);
        reset = 1'b0;
        step(1'b1, 32'h01000007);
        chk("fe timing pulse", frame_end, 1'b1);
        chk("fe timing others", {data_enable, frame_start, in_frame, header_error,
                                 packet_error}, 32'h0);
        step(1'b0, 32'h0);
        chk("fe timing one-shot", frame_end, 1'b0);

        // Directed packet table.
        for (int i = 0; i < 20; i++) begin
            hdr = tbl[i].auto_ecc ? with_ecc(tbl[i].hdr) : tbl[i].hdr;
            run_packet(hdr, tbl[i].nwords);
            check_packet($sformatf("tbl%0d", i), hdr, tbl[i].e);
        end

        // Reset asserted after the first payload word aborts silently.
        step(1'b1, 32'h2A080035);
        w = $urandom;
        step(1'b1, w);
        chk("rst_mid first word en", data_enable, 1'b1);
        chk("rst_mid first word data", {data_out[0], data_out[1], data_out[2], data_out[3]}, w);
        reset = 1'b1;
        step(1'b1, $urandom);
        chk("rst_mid flags", {data_enable, line_start, frame_start, frame_end, in_frame,
                              header_error, packet_error}, 32'h0);
        chk("rst_mid data_out", {data_out[0], data_out[1], data_out[2], data_out[3]}, 32'h0);
        reset = 1'b0;
        step(1'b0, 32'h0);
        chk("rst_mid after", {header_error, packet_error, in_frame, data_enable}, 32'h0);
        last_word = 32'h0;
        model_in_frame = 0;
        run_packet(32'h00000000, 0);
        check_packet("rst_mid fs", 32'h00000000, '{1, 0, 0, 0, 0, 1});

        // Randomized packets against the reference model.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: hdr = 32'h00000000;
                1: hdr = 32'h01000000;
                2, 3, 4, 5: begin
                    wc = 16'(4 * $urandom_range(1, 16));
                    hdr = {8'h2A, wc[7:0], wc[15:8], 8'h00};
                end
                6: begin
                    wc = 16'($urandom_range(0, 70));
                    hdr = {8'h2A, wc[7:0], wc[15:8], 8'h00};
                end
                7: begin
                    wc = 16'(4 * $urandom_range(0, 8));
                    hdr = {8'($urandom_range(0, 255)), wc[7:0], wc[15:8], 8'h00};
                end
                8: begin
                    wc = ($urandom_range(0, 1) == 0) ? 16'd640 : 16'(644 + $urandom_range(0, 3));
                    hdr = {8'h2A, wc[7:0], wc[15:8], 8'h00};
                end
                default: begin
                    wc = 16'(4 * $urandom_range(1, 8));
                    hdr = {8'h2A, wc[7:0], wc[15:8], 8'h00};
                end
            endcase
            hdr = with_ecc(hdr);
            if (r == 9) hdr[$urandom_range(0, 7)] ^= 1'b1;
            wc = {hdr[15:8], hdr[23:16]};
            words = int'(wc) / 4;
            nw = (hdr[31:24] == 8'h2A) ? $urandom_range(0, words + 2) : $urandom_range(0, 3);
            e = model_packet(hdr, nw, model_in_frame);
            run_packet(hdr, nw);
            check_packet($sformatf("rnd%0d", n), hdr, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
